multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Drives the 2-bit ALU-operation class consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Handshakes with a variable-latency unified instruction/data memory.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag, combinational from the current cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_write  out  1  request is a store; qualifies mem_req.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC; equals pc_update | (branch & zero).
- reg_write  out  1  register-file write enable.
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=regA.
- alu_src_b  out  2  ALU B select: 00=regB, 01=ImmExt, 10=const 4.
- alu_op  out  2  00=add, 01=sub, 10=decode by funct fields.
- result_src  out  2  result select: 00=ALUOut, 01=mem data, 10=ALU result.
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B.
- illegal  out  1  sticky; an unsupported opcode has been decoded.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous: state=FETCH, instret=0, illegal=0.
- All outputs are Moore-decoded from state. Exceptions: pc_write (uses zero); ir_write and pc_update in FETCH (gated by mem_ready).
- Default for every output is 0.
- FETCH:
  - Asserts mem_req and adr_src=0.
  - Holds until mem_ready.
  - On the mem_ready cycle: ir_write=1, pc_update=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10 (PC+4), then go to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=10 (branch target into ALUOut).
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BEQ; anything else -> ILLEGAL.
- MEMADR:
  - alu_src_a=10, alu_src_b=01, alu_op=00.
  - imm_src=00 for a load, 01 for a store (opcode[5]).
  - Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - mem_req=1, adr_src=1.
  - Holds until mem_ready, then -> MEMWB.
- MEMWB:
  - result_src=01, reg_write=1.
  - Retire; -> FETCH.
- MEMWRITE:
  - mem_req=1, mem_write=1, adr_src=1.
  - Retire on mem_ready; -> FETCH.
- EXECR:
  - alu_src_a=10, alu_src_b=00, alu_op=10.
  - -> ALUWB.
- ALUWB:
  - result_src=00, reg_write=1.
  - Retire; -> FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - pc_write=zero.
  - Retire; -> FETCH.
- ILLEGAL:
  - Sets illegal=1; all enables stay 0.
  - Remains in ILLEGAL until reset.
- Latency with zero-wait memory (mem_ready=1 on first request cycle): beq 3 cycles, R-type 4, sw 4, lw 5. Each wait cycle adds 1.
- mem_req and mem_write stay stable while waiting; no enable pulses during wait cycles.
- instret increments by 1 on each retiring cycle and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately. No write enable is asserted while reset is high.

Optional Feature:
- MC_ITYPE_EN defined:
  - DECODE sends opcode 0010011 to EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10.
  - EXECI -> ALUWB.
  - I-type latency is 4 cycles.
- MC_ITYPE_EN undefined: opcode 0010011 goes to ILLEGAL.

Decomposition:
- Shared package holds:
  - State enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, ILLEGAL).
  - Opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ).
  - ALUOp, mux-select and imm_src encodings, shared with the ALU control decoder and the datapath.
- One sub-module is natural: instr_counter (enable, wrap, async reset), instantiated for instret.
- The FSM stays flat.

Test Plan:
- Zero-wait R-type (opcode 0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; reg_write high exactly in cycle 4; alu_op=10 in EXECR; instret 0->1.
- lw with mem_ready delayed 2 cycles in both FETCH and MEMREAD -> 9 total cycles; mem_req held steady; ir_write and reg_write each a single-cycle pulse.
- beq with zero=1 -> pc_write in FETCH and BEQ (2 pulses); with zero=0 -> only the FETCH pulse; both take 3 cycles.
- Opcode 1111111 -> ILLEGAL after DECODE; illegal=1 stays set; no mem_req for 20 cycles; reset returns to FETCH with illegal=0.
- Reset asserted during MEMWRITE wait -> next cycle state=FETCH; mem_write=0; instret=0.
- Opcode 0010011: with MC_ITYPE_EN -> retires in 4 cycles with alu_src_b=01; without it -> illegal=1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control path:
// FSM states, opcodes, ALUOp, mux selects and immediate formats.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Loads and stores differ only in opcode bit 5.
  function automatic logic is_store(input logic [6:0] op);
    return op[5];
  endfunction

endpackage

// File: rtl/multicycle_control_instr_counter.sv
// Wrapping retired-instruction counter with async active-high reset.
// Ports: clk, reset, en (count this cycle), count (W bits).
module instr_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V datapath.
// Inputs: clk, reset (async, high), opcode, zero, mem_ready.
// Outputs: mem_req/mem_write/adr_src, ir_write, pc_write,
// reg_write, alu_src_a/b, alu_op, result_src, imm_src,
// illegal (sticky), instret (CNT_W bits).
// Define MC_ITYPE_EN to execute OP-IMM (0010011) via EXECI.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  logic   pc_update;
  logic   branch;
  logic   retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        FETCH:
          if (mem_ready) state <= DECODE;
        DECODE:
          case (opcode)
            OP_LOAD,
            OP_STORE: state <= MEMADR;
            OP_R:     state <= EXECR;
            OP_BEQ:   state <= BEQ;
`ifdef MC_ITYPE_EN
            OP_I:     state <= EXECI;
`endif
            default: begin
              state   <= ILLEGAL;
              illegal <= 1'b1;
            end
          endcase
        MEMADR:
          state <= is_store(opcode) ? MEMWRITE : MEMREAD;
        MEMREAD:
          if (mem_ready) state <= MEMWB;
        MEMWRITE:
          if (mem_ready) state <= FETCH;
        EXECR,
        EXECI:
          state <= ALUWB;
        MEMWB,
        ALUWB,
        BEQ:
          state <= FETCH;
        ILLEGAL:
          state <= ILLEGAL;
        default:
          state <= FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        imm_src   = is_store(opcode) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
      end
      EXECR: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BEQ: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    pc_write = pc_update | (branch & zero);
    // State already reads FETCH during reset; keep the
    // datapath and memory quiet until reset is released.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  instr_counter #(
    .W(CNT_W)
  ) u_instret (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control.
// Reference model works per instruction: latency, pulse counts.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src;
  logic        ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic [1:0]  result_src, imm_src;
  logic        illegal;
  logic [31:0] instret;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .instret    (instret)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // kinds: 0 lw, 1 sw, 2 R, 3 beq, 4 I
  function automatic logic [6:0] opc(input int k);
    case (k)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b1100011;
      default: return 7'b0010011;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("post_rst_mem_req", 32'(mem_req), 1);
    chk("post_rst_adr_src", 32'(adr_src), 0);
  endtask

  // One instruction; w0/w1 = wait cycles of fetch/data access.
  task automatic run_instr(input int k, input int w0,
                           input int w1, input logic z);
    int cyc = 0, irp = 0, rwp = 0, pwp = 0;
    int mrq = 0, mwr = 0, acc = 0, cnt = 0;
    int ph = -1, rwc = 0;
    int lat, exp_mrq, exp_mwr;
    bit done = 0;
    bit ldst, wr;
    logic [31:0] i0;
    i0 = instret;
    opcode = opc(k);
    zero = z;
    while (!done && cyc < 40) begin
      mem_ready = mem_req && (cnt >= ((acc == 0) ? w0 : w1));
      #1;
      cyc++;
      if (ir_write) ph = 0;
      else if (ph >= 0) ph++;
      if (ph == 0 && ir_write) begin
        chk("fetch_src_b", 32'(alu_src_b), 2);
        chk("fetch_res", 32'(result_src), 2);
      end
      if (ph == 1) begin
        chk("dec_src_a", 32'(alu_src_a), 1);
        chk("dec_src_b", 32'(alu_src_b), 1);
        chk("dec_imm", 32'(imm_src), 2);
        chk("dec_aluop", 32'(alu_op), 0);
      end
      if (ph == 2) begin
        chk("ex_src_a", 32'(alu_src_a), 2);
        case (k)
          0, 1: begin
            chk("adr_src_b", 32'(alu_src_b), 1);
            chk("adr_imm", 32'(imm_src), (k == 1) ? 1 : 0);
            chk("adr_aluop", 32'(alu_op), 0);
          end
          2: begin
            chk("exr_src_b", 32'(alu_src_b), 0);
            chk("exr_aluop", 32'(alu_op), 2);
          end
          3: begin
            chk("beq_src_b", 32'(alu_src_b), 0);
            chk("beq_aluop", 32'(alu_op), 1);
            chk("beq_pcw", 32'(pc_write), 32'(z));
          end
          default: begin
            chk("exi_src_b", 32'(alu_src_b), 1);
            chk("exi_imm", 32'(imm_src), 0);
            chk("exi_aluop", 32'(alu_op), 2);
          end
        endcase
      end
      if (ir_write) irp++;
      if (reg_write) begin
        rwp++;
        rwc = cyc;
        chk("wb_res", 32'(result_src), (k == 0) ? 1 : 0);
      end
      if (pc_write) pwp++;
      if (mem_req) mrq++;
      if (mem_write) mwr++;
      if (mem_req) begin
        if (mem_ready) begin
          acc++;
          cnt = 0;
        end else cnt++;
      end
      @(posedge clk);
      #1;
      if (instret !== i0) done = 1;
      @(negedge clk);
    end
    ldst = (k == 0 || k == 1);
    wr = (k == 0 || k == 2 || k == 4);
    case (k)
      0: lat = 5;
      3: lat = 3;
      default: lat = 4;
    endcase
    lat += w0 + (ldst ? w1 : 0);
    exp_mrq = w0 + 1 + (ldst ? w1 + 1 : 0);
    exp_mwr = (k == 1) ? w1 + 1 : 0;
    chk("latency", cyc, lat);
    chk("instret_inc", instret, i0 + 1);
    chk("ir_pulses", irp, 1);
    chk("rw_pulses", rwp, wr ? 1 : 0);
    chk("pcw_pulses", pwp, (k == 3 && z) ? 2 : 1);
    chk("mreq_cycles", mrq, exp_mrq);
    chk("mwr_cycles", mwr, exp_mwr);
    if (wr) chk("rw_cycle", rwc, lat);
  endtask

  // Zero-wait fetch/decode of an unsupported opcode.
  task automatic illegal_seq(input logic [6:0] op);
    int bad = 0;
    opcode = op;
    mem_ready = 1'b1;
    #1;
    chk("ill_fetch_ir", 32'(ir_write), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ill_decode_flag", 32'(illegal), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ill_flag_set", 32'(illegal), 1);
    for (int i = 0; i < 20; i++) begin
      if (mem_req || ir_write || pc_write || reg_write) bad++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("ill_quiet", bad, 0);
    chk("ill_sticky", 32'(illegal), 1);
  endtask

  initial begin
    int kmax, k;
`ifdef MC_ITYPE_EN
    kmax = 4;
`else
    kmax = 3;
`endif
    do_reset();
    run_instr(2, 0, 0, 1'b0);
    run_instr(0, 2, 2, 1'b0);
    run_instr(3, 0, 0, 1'b1);
    run_instr(3, 0, 0, 1'b0);
    run_instr(1, 1, 3, 1'b0);
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, kmax));
      run_instr(k, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end
    // abort a store that is waiting on memory
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    #1;
    chk("sw_fetch_ir", 32'(ir_write), 1);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sw_wait_mwr", 32'(mem_write), 1);
    chk("sw_wait_req", 32'(mem_req), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_mwr", 32'(mem_write), 0);
    chk("abort_instret", instret, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_fetch_req", 32'(mem_req), 1);
    chk("abort_fetch_adr", 32'(adr_src), 0);
    chk("abort_fetch_mwr", 32'(mem_write), 0);
    chk("abort_instret2", instret, 0);
    illegal_seq(7'b1111111);
    do_reset();
`ifdef MC_ITYPE_EN
    run_instr(4, 0, 0, 1'b0);
`else
    illegal_seq(7'b0010011);
`endif
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
